// File: rtl/rfblackwidow_mem_req_sched_pkg.sv
// rtl/rfblackwidow_mem_req_sched_pkg.sv - memory request types, size codes and byte-select helper
//
// Shared by the request queue and the memory request scheduler.
//   mem_request_t : queue head entry (tid, func, sz, adr, dat)
//   mem_func_e    : MR_LOAD (sign-extend), MR_LOADZ (zero-extend), MR_STORE
//   mem_size_t    : byt/wyde/tetra/octa/penta/deci size codes
//   fn_sel        : contiguous byte-select mask for a size code
package rfblackwidow_mem_req_sched_pkg;

  localparam int AWID = 32;

  typedef enum logic [1:0] {
    MR_LOAD  = 2'd0,
    MR_LOADZ = 2'd1,
    MR_STORE = 2'd2
  } mem_func_e;

  typedef logic [2:0] mem_size_t;

  localparam mem_size_t SZ_BYT   = 3'd0;  // 1 byte
  localparam mem_size_t SZ_WYDE  = 3'd1;  // 2 bytes
  localparam mem_size_t SZ_TETRA = 3'd2;  // 4 bytes
  localparam mem_size_t SZ_OCTA  = 3'd3;  // 8 bytes
  localparam mem_size_t SZ_PENTA = 3'd4;  // 5 bytes
  localparam mem_size_t SZ_DECI  = 3'd5;  // 10 bytes

  typedef struct packed {
    logic [7:0]      tid;
    mem_func_e       func;
    mem_size_t       sz;
    logic [AWID-1:0] adr;
    logic [127:0]    dat;
  } mem_request_t;

  // Unassigned size codes fall back to an octa access.
  function automatic logic [15:0] fn_sel(input mem_size_t sz);
    logic [15:0] sel;
    case (sz)
      SZ_BYT:   sel = 16'h0001;
      SZ_WYDE:  sel = 16'h0003;
      SZ_TETRA: sel = 16'h000F;
      SZ_PENTA: sel = 16'h001F;
      SZ_OCTA:  sel = 16'h00FF;
      SZ_DECI:  sel = 16'h03FF;
      default:  sel = 16'h00FF;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rfblackwidow_mem_req_sched_if.sv
// rtl/rfblackwidow_mem_req_sched_if.sv - 128-bit data bus between scheduler and memory
//
// master: cyc, stb, we, sel[15:0], adr[AWID-1:0], dato[127:0] out; ack, err, dati[127:0] in
// slave : mirror image of master
interface rfblackwidow_mem_req_sched_if;
  import rfblackwidow_mem_req_sched_pkg::*;

  logic            cyc;
  logic            stb;
  logic            we;
  logic [15:0]     sel;
  logic [AWID-1:0] adr;
  logic [127:0]    dato;
  logic            ack;
  logic            err;
  logic [127:0]    dati;

  modport master (
    output cyc, stb, we, sel, adr, dato,
    input  ack, err, dati
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dato,
    output ack, err, dati
  );

endinterface

// File: rtl/rfblackwidow_mem_req_sched_load_align.sv
// rtl/rfblackwidow_mem_req_sched_load_align.sv - load data alignment and extension
//
// Purely combinational.
//   data[255:0]   : {hi, lo} bus read data of the (possibly split) access
//   ofs[3:0]      : byte offset of the request within its 16-byte block
//   sz, func      : size code and load kind
//   result[127:0] : data shifted down to byte 0, masked to the access size,
//                   sign-extended for MR_LOAD, zero-extended otherwise
module rfblackwidow_mem_req_sched_load_align
  import rfblackwidow_mem_req_sched_pkg::*;
(
  input  logic [255:0] data,
  input  logic [3:0]   ofs,
  input  mem_size_t    sz,
  input  mem_func_e    func,
  output logic [127:0] result
);

  logic [127:0] raw;
  logic [127:0] bmask;
  logic [15:0]  bsel;
  logic         sign;

  always_comb begin
    raw   = 128'(data >> {ofs, 3'b000});
    bsel  = fn_sel(sz);
    bmask = '0;
    sign  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bmask[i*8 +: 8] = {8{bsel[i]}};
      // Last selected lane wins, i.e. the most significant byte of the access.
      if (bsel[i]) sign = raw[i*8+7];
    end
    result = raw & bmask;
    if (func == MR_LOAD && sign) result = result | ~bmask;
  end

endmodule

// File: rtl/rfblackwidow_mem_req_sched.sv
// rtl/rfblackwidow_mem_req_sched.sv - memory request scheduler: queue head -> bus -> response
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   q_valid, q_req, q_rd     : queue head and one-cycle pop pulse
//   bus (master)             : 128-bit data bus; accesses crossing a 16-byte
//                              boundary take two back-to-back bus cycles
//   resp_v, resp_rdy         : response handshake, fields held until accepted
//   resp_tid, resp_dat, resp_err : completed tid, aligned load data, bus error/timeout
module rfblackwidow_mem_req_sched
  import rfblackwidow_mem_req_sched_pkg::*;
#(
  parameter logic [7:0] TMO = 8'd255
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         q_valid,
  input  mem_request_t q_req,
  output logic         q_rd,
  rfblackwidow_mem_req_sched_if.master bus,
  output logic         resp_v,
  input  logic         resp_rdy,
  output logic [7:0]   resp_tid,
  output logic [127:0] resp_dat,
  output logic         resp_err
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_e;

  state_e          state, state_nxt;
  mem_request_t    req;
  logic [31:0]     sel32, sel32_in;
  logic            split;
  logic [127:0]    lo, hi, load_dat;
  logic            err_r;
  logic [7:0]      tmo_cnt;
  logic [255:0]    st_shift;
  logic [AWID-1:0] blk_adr;
  logic            in_acc;
  logic            acc_fail;

  assign sel32_in = {16'h0, fn_sel(q_req.sz)} << q_req.adr[3:0];
  assign st_shift = {128'h0, req.dat} << {req.adr[3:0], 3'b000};
  assign blk_adr  = {req.adr[AWID-1:4], 4'h0};
  assign in_acc   = (state == ACC1) || (state == ACC2);
  // err beats a simultaneous ack; an ack on the last allowed cycle beats the timeout.
  assign acc_fail = in_acc && (bus.err || (!bus.ack && tmo_cnt == TMO));

  rfblackwidow_mem_req_sched_load_align u_load_align (
    .data   ({hi, lo}),
    .ofs    (req.adr[3:0]),
    .sz     (req.sz),
    .func   (req.func),
    .result (load_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    q_rd      = 1'b0;
    bus.cyc   = 1'b0;
    bus.stb   = 1'b0;
    bus.we    = 1'b0;
    bus.sel   = '0;
    bus.adr   = '0;
    bus.dato  = '0;
    resp_v    = 1'b0;
    resp_tid  = '0;
    resp_dat  = '0;
    resp_err  = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so the queue never advances during reset.
        if (q_valid && !rst) begin
          q_rd      = 1'b1;
          state_nxt = ACC1;
        end
      end
      ACC1: begin
        bus.cyc  = 1'b1;
        bus.stb  = 1'b1;
        bus.we   = (req.func == MR_STORE);
        bus.adr  = blk_adr;
        bus.sel  = sel32[15:0];
        bus.dato = st_shift[127:0];
        if (acc_fail)     state_nxt = RESP;
        else if (bus.ack) state_nxt = split ? ACC2 : RESP;
      end
      ACC2: begin
        bus.cyc  = 1'b1;
        bus.stb  = 1'b1;
        bus.we   = (req.func == MR_STORE);
        bus.adr  = blk_adr + AWID'(16);
        bus.sel  = sel32[31:16];
        bus.dato = st_shift[255:128];
        if (acc_fail || bus.ack) state_nxt = RESP;
      end
      RESP: begin
        resp_v   = 1'b1;
        resp_tid = req.tid;
        resp_dat = (err_r || req.func == MR_STORE) ? '0 : load_dat;
        resp_err = err_r;
        if (resp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req     <= '0;
      sel32   <= '0;
      split   <= 1'b0;
      lo      <= '0;
      hi      <= '0;
      err_r   <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (q_valid) begin
            req     <= q_req;
            sel32   <= sel32_in;
            split   <= |sel32_in[31:16];
            lo      <= '0;
            hi      <= '0;
            err_r   <= 1'b0;
            tmo_cnt <= '0;
          end
        end
        ACC1, ACC2: begin
          if (acc_fail) begin
            err_r <= 1'b1;
          end else if (bus.ack) begin
            if (state == ACC1) lo <= bus.dati;
            else               hi <= bus.dati;
            tmo_cnt <= '0;  // fresh budget for the second access
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rfblackwidow_mem_req_sched.sv
// tb/tb_rfblackwidow_mem_req_sched.sv - scoreboard bench for the memory request scheduler
module tb_rfblackwidow_mem_req_sched;
  import rfblackwidow_mem_req_sched_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         q_valid;
  mem_request_t q_req;
  logic         q_rd;
  logic         resp_v;
  logic         resp_rdy;
  logic [7:0]   resp_tid;
  logic [127:0] resp_dat;
  logic         resp_err;

  always #5 clk = ~clk;

  rfblackwidow_mem_req_sched_if bus();

  rfblackwidow_mem_req_sched #(.TMO(8'd255)) dut (
    .clk      (clk),
    .rst      (rst),
    .q_valid  (q_valid),
    .q_req    (q_req),
    .q_rd     (q_rd),
    .bus      (bus),
    .resp_v   (resp_v),
    .resp_rdy (resp_rdy),
    .resp_tid (resp_tid),
    .resp_dat (resp_dat),
    .resp_err (resp_err)
  );

  typedef struct {
    logic [7:0]   tid;
    logic [127:0] dat;
    logic         err;
    int           acc;
  } exp_t;

  typedef struct {
    int           lat0;
    int           lat1;
    int           err_acc;   // access index answered with err, -1 for none
    bit           err_ack;   // also raise ack alongside err
    bit           tmo;       // never answer
    bit           fixed;     // return fdat instead of memory image
    logic [127:0] fdat;
    bit           use_x;     // expected load data given explicitly
    logic [127:0] xdat;
  } plan_t;

  exp_t         sb[$];
  mem_request_t cur;
  plan_t        cur_plan;
  int           acc_done;
  int           rdy_mode;   // 0 random, 1 high, 2 low
  logic [7:0]   salt;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic abort(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "run stopped");
  endtask

  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd3: return 8;
      3'd4: return 5;
      3'd5: return 10;
      default: return 8;
    endcase
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1;
    return h[23:16] ^ salt;
  endfunction

  function automatic logic [127:0] model_load(input mem_request_t r);
    logic [127:0] v;
    int n;
    v = '0;
    n = nbytes(r.sz);
    for (int i = 0; i < n; i++) v[i*8 +: 8] = mem_byte(r.adr + 32'(i));
    if (r.func == MR_LOAD && v[n*8-1])
      for (int i = n; i < 16; i++) v[i*8 +: 8] = 8'hFF;
    return v;
  endfunction

  // Present a request, wait for the pop, then record the expected response.
  task automatic issue(input mem_request_t r, input plan_t p, output int waited);
    exp_t e;
    int   n;
    bit   sp;
    q_req   = r;
    q_valid = 1'b1;
    waited  = 0;
    forever begin
      @(negedge clk);
      if (q_rd) break;
      waited++;
      if (waited > 2000) abort("pop_wait");
    end
    cur      = r;
    cur_plan = p;
    acc_done = 0;
    n  = nbytes(r.sz);
    sp = (int'(r.adr[3:0]) + n) > 16;
    e.tid = r.tid;
    e.err = p.tmo || p.err_acc == 0 || (p.err_acc == 1 && sp);
    if (p.tmo)                         e.acc = 0;
    else if (p.err_acc == 0)           e.acc = 1;
    else                               e.acc = sp ? 2 : 1;
    if (e.err || r.func == MR_STORE)   e.dat = '0;
    else if (p.use_x)                  e.dat = p.xdat;
    else                               e.dat = model_load(r);
    sb.push_back(e);
    @(posedge clk); #1;
    q_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 || resp_v) begin
      @(posedge clk); #1;
      k++;
      if (k > 1000) abort("drain");
    end
  endtask

  function automatic plan_t plan_ok(input int l0, input int l1);
    plan_t p;
    p.lat0 = l0; p.lat1 = l1; p.err_acc = -1; p.err_ack = 0; p.tmo = 0;
    p.fixed = 0; p.fdat = '0; p.use_x = 0; p.xdat = '0;
    return p;
  endfunction

  // Bus slave: answers per plan and checks each completed access against the request.
  task automatic check_access(input int k);
    logic [31:0]  base, off;
    logic [15:0]  xsel;
    logic [127:0] xdato, lmask;
    int n;
    n     = nbytes(cur.sz);
    base  = {cur.adr[31:4], 4'h0} + 32'(16 * k);
    xsel  = '0;
    xdato = '0;
    lmask = '0;
    for (int j = 0; j < 16; j++) begin
      off = base + 32'(j) - cur.adr;
      if (off < 32'(n)) begin
        xsel[j]          = 1'b1;
        xdato[j*8 +: 8]  = cur.dat[off*8 +: 8];
        lmask[j*8 +: 8]  = 8'hFF;
      end
    end
    chk("bus_stb", 128'(bus.stb), 128'(1'b1));
    chk("bus_adr", 128'(bus.adr), 128'(base));
    chk("bus_we",  128'(bus.we),  128'(cur.func == MR_STORE));
    chk("bus_sel", 128'(bus.sel), 128'(xsel));
    if (cur.func == MR_STORE) chk("bus_dato", bus.dato & lmask, xdato);
  endtask

  int acc_k  = 0;
  int wait_c = 0;
  always begin
    @(posedge clk); #1;
    bus.ack  = 1'b0;
    bus.err  = 1'b0;
    bus.dati = '0;
    if (!bus.cyc) begin
      acc_k  = 0;
      wait_c = 0;
    end else if (!cur_plan.tmo) begin
      if (wait_c >= ((acc_k == 0) ? cur_plan.lat0 : cur_plan.lat1)) begin
        check_access(acc_k);
        if (cur_plan.err_acc == acc_k) begin
          bus.err = 1'b1;
          bus.ack = cur_plan.err_ack;
        end else begin
          bus.ack = 1'b1;
          for (int j = 0; j < 16; j++)
            bus.dati[j*8 +: 8] = cur_plan.fixed ? cur_plan.fdat[j*8 +: 8]
                                                : mem_byte(bus.adr + 32'(j));
        end
        acc_k++;
        acc_done++;
        wait_c = 0;
      end else begin
        wait_c++;
      end
    end
  end

  always begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       resp_rdy = 1'($urandom_range(0, 1));
      1:       resp_rdy = 1'b1;
      default: resp_rdy = 1'b0;
    endcase
  end

  // Response monitor: pops the scoreboard on every accepted response.
  always begin
    exp_t e;
    @(negedge clk);
    if (!rst && resp_v && resp_rdy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp_unexpected: got tid %h with empty scoreboard", resp_tid);
      end else begin
        e = sb.pop_front();
        chk("resp_tid", 128'(resp_tid), 128'(e.tid));
        chk("resp_dat", resp_dat, e.dat);
        chk("resp_err", 128'(resp_err), 128'(e.err));
        chk("bus_accesses", 128'(acc_done), 128'(e.acc));
      end
    end
  end

  initial begin
    mem_request_t r, r2;
    plan_t        p;
    int           w;
    logic [7:0]   h_tid;
    logic [127:0] h_dat;
    logic         h_err;

    salt     = 8'($urandom);
    rdy_mode = 1;
    cur_plan = plan_ok(0, 0);
    cur      = '0;
    acc_done = 0;
    q_req    = '0;
    q_valid  = 1'b1;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q_rd",     128'(q_rd),     '0);
    chk("rst_cyc",      128'(bus.cyc),  '0);
    chk("rst_stb",      128'(bus.stb),  '0);
    chk("rst_we",       128'(bus.we),   '0);
    chk("rst_sel",      128'(bus.sel),  '0);
    chk("rst_adr",      128'(bus.adr),  '0);
    chk("rst_dato",     bus.dato,       '0);
    chk("rst_resp_v",   128'(resp_v),   '0);
    chk("rst_resp_tid", 128'(resp_tid), '0);
    chk("rst_resp_dat", resp_dat,       '0);
    chk("rst_resp_err", 128'(resp_err), '0);
    q_valid = 1'b0;
    rst     = 1'b0;
    @(posedge clk); #1;

    // Tetra sign-extending load, lanes 4..7 = 0x80000001, 1-cycle ack.
    r = '{tid: 8'h11, func: MR_LOAD, sz: SZ_TETRA, adr: 32'h1004, dat: '0};
    p = plan_ok(0, 0);
    p.fixed = 1; p.fdat = {64'h0, 32'h8000_0001, 32'h0};
    p.use_x = 1; p.xdat = {{96{1'b1}}, 32'h8000_0001};
    issue(r, p, w);
    chk("lat_acc1_resp_v", 128'(resp_v), '0);
    @(posedge clk); #1;
    chk("lat_resp_v", 128'(resp_v), 128'(1'b1));
    drain();

    // Same access zero-extended.
    r.tid = 8'h12; r.func = MR_LOADZ;
    p.xdat = {96'h0, 32'h8000_0001};
    issue(r, p, w);
    drain();

    // Octa store crossing the 16-byte boundary.
    r = '{tid: 8'h33, func: MR_STORE, sz: SZ_OCTA, adr: 32'h200C, dat: 128'h1122_3344_5566_7788};
    issue(r, plan_ok(0, 0), w);
    chk("st1_adr",  128'(bus.adr), 128'(32'h2000));
    chk("st1_sel",  128'(bus.sel), 128'(16'hF000));
    chk("st1_lane", 128'(bus.dato[127:96]), 128'(32'h5566_7788));
    @(posedge clk); #1;
    chk("st2_stb",  128'(bus.stb), 128'(1'b1));
    chk("st2_adr",  128'(bus.adr), 128'(32'h2010));
    chk("st2_sel",  128'(bus.sel), 128'(16'h000F));
    chk("st2_lane", 128'(bus.dato[31:0]), 128'(32'h1122_3344));
    drain();

    // Split load, err (with ack) on the first access.
    r = '{tid: 8'h44, func: MR_LOAD, sz: SZ_OCTA, adr: 32'h300A, dat: '0};
    p = plan_ok(1, 0);
    p.err_acc = 0; p.err_ack = 1;
    issue(r, p, w);
    drain();

    // Timeout with the consumer stalled; a new head waits meanwhile.
    rdy_mode = 2;
    r = '{tid: 8'h55, func: MR_LOAD, sz: SZ_TETRA, adr: 32'h4000, dat: '0};
    p = plan_ok(0, 0);
    p.tmo = 1;
    issue(r, p, w);
    q_req   = '{tid: 8'h56, func: MR_LOAD, sz: SZ_BYT, adr: 32'h4100, dat: '0};
    q_valid = 1'b1;
    w = 0;
    while (bus.cyc) begin
      @(posedge clk); #1;
      w++;
      if (w > 400) abort("timeout_wait");
    end
    chk("tmo_resp_v",   128'(resp_v),   128'(1'b1));
    chk("tmo_resp_err", 128'(resp_err), 128'(1'b1));
    chk("tmo_resp_tid", 128'(resp_tid), 128'(8'h55));
    h_tid = resp_tid; h_dat = resp_dat; h_err = resp_err;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_resp_v",   128'(resp_v),   128'(1'b1));
      chk("hold_resp_tid", 128'(resp_tid), 128'(h_tid));
      chk("hold_resp_dat", resp_dat,       h_dat);
      chk("hold_resp_err", 128'(resp_err), 128'(h_err));
      chk("hold_q_rd",     128'(q_rd),     '0);
    end
    q_valid  = 1'b0;
    rdy_mode = 1;
    drain();

    // Reset while the second access of a split load is pending.
    r = '{tid: 8'h66, func: MR_LOAD, sz: SZ_OCTA, adr: 32'h500C, dat: '0};
    issue(r, plan_ok(0, 8), w);
    w = 0;
    while (!(bus.cyc && bus.adr == 32'h5010)) begin
      @(posedge clk); #1;
      w++;
      if (w > 50) abort("acc2_wait");
    end
    r2      = '{tid: 8'h67, func: MR_LOADZ, sz: SZ_WYDE, adr: 32'h600F, dat: '0};
    rst     = 1'b1;
    q_req   = r2;
    q_valid = 1'b1;
    @(posedge clk); #1;
    chk("rstacc_cyc",    128'(bus.cyc), '0);
    chk("rstacc_stb",    128'(bus.stb), '0);
    chk("rstacc_q_rd",   128'(q_rd),    '0);
    chk("rstacc_resp_v", 128'(resp_v),  '0);
    rst = 1'b0;
    void'(sb.pop_back());
    issue(r2, plan_ok(0, 0), w);
    chk("pop_after_reset", 128'(w), '0);
    drain();

    // Randomised traffic.
    rdy_mode = 0;
    for (int t = 0; t < 150; t++) begin
      int ek;
      r.tid  = 8'($urandom);
      r.func = mem_func_e'($urandom_range(0, 2));
      r.sz   = 3'($urandom_range(0, 7));
      r.adr  = $urandom;
      r.dat  = {$urandom, $urandom, $urandom, $urandom};
      p = plan_ok($urandom_range(0, 3), $urandom_range(0, 3));
      ek = $urandom_range(0, 9);
      p.err_acc = (ek < 2) ? ek : -1;
      p.err_ack = 1'($urandom_range(0, 1));
      issue(r, p, w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
